// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Segment codes are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] DIG_OFF = 4'hF;

   // Entry 15 is written first, so the list reads F..0 from left to right.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic {
      S_DEAD = 1'b0,
      S_ON   = 1'b1
   } state_e;

endpackage

// File: rtl/seg7_scan_driver_hex2seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex2seg
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver: per-frame input latch, dead-time gap,
// optional leading-zero blanking and per-digit decimal points.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = 25000,
   parameter int BLANK_CYC = 250
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] display_num,
   input  logic [3:0]  dp_en,
   input  logic        blank_lz,
   output logic [7:0]  seg,
   output logic [3:0]  dig,
   output logic        frame_start,
   output logic        dbg_state
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
   localparam state_e ST_RESET = (BLANK_CYC > 0) ? S_DEAD : S_ON;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   state_e        state_q, state_d;
   logic [15:0]   num_q;
   logic [3:0]    dp_q;
   logic          lz_q;
   logic [7:0]    seg_q, seg_d;
   logic [3:0]    dig_q, dig_d;
   logic          fs_q;

   logic          frame_edge;
   logic          slot_last;
   logic [15:0]   num_eff;
   logic [3:0]    dp_eff;
   logic          lz_eff;
   logic [3:0]    nib;
   logic [6:0]    nib_seg;
   logic          blanked;

   // The latch edge also feeds the slot-0 decode, so a BLANK_CYC=0 build
   // shows the freshly captured word on its first output cycle.
   assign frame_edge = (cnt_q == '0) && (idx_q == 2'd0);
   assign slot_last  = (cnt_q == CNT_LAST);
   assign num_eff    = frame_edge ? display_num : num_q;
   assign dp_eff     = frame_edge ? dp_en       : dp_q;
   assign lz_eff     = frame_edge ? blank_lz    : lz_q;
   assign nib        = num_eff[{idx_q, 2'b00} +: 4];

   hex2seg u_hex2seg (
      .nib_i (nib),
      .seg_o (nib_seg)
   );

   always_comb begin
      blanked = 1'b0;
      case (idx_q)
         2'd3:    blanked = lz_eff && (num_eff[15:12] == 4'h0);
         2'd2:    blanked = lz_eff && (num_eff[15:8]  == 8'h00);
         2'd1:    blanked = lz_eff && (num_eff[15:4]  == 12'h000);
         default: blanked = 1'b0;
      endcase
   end

   always_comb begin
      cnt_d   = slot_last ? '0 : cnt_q + CW'(1);
      idx_d   = slot_last ? idx_q + 2'd1 : idx_q;
      state_d = state_q;
      case (state_q)
         S_DEAD: if ((BLANK_CYC == 0) || (cnt_q == DEAD_LAST)) state_d = S_ON;
         S_ON:   if (slot_last && (BLANK_CYC > 0))             state_d = S_DEAD;
         default: state_d = ST_RESET;
      endcase
      seg_d = SEG_OFF;
      dig_d = DIG_OFF;
      if ((state_q == S_ON) && !blanked) begin
         dig_d = ~(4'b0001 << idx_q);
         seg_d = {~dp_eff[idx_q], nib_seg};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         state_q <= ST_RESET;
         num_q   <= 16'h0000;
         dp_q    <= 4'h0;
         lz_q    <= 1'b0;
         seg_q   <= SEG_OFF;
         dig_q   <= DIG_OFF;
         fs_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         fs_q    <= frame_edge;
         if (frame_edge) begin
            num_q <= display_num;
            dp_q  <= dp_en;
            lz_q  <= blank_lz;
         end
      end
   end

   assign seg         = seg_q;
   assign dig         = dig_q;
   assign frame_start = fs_q;
   assign dbg_state   = state_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed 4-digit seven-segment display driver consuming the 16-bit `display_num` hex word produced by the keypad scanner. It sits between the keypad path and the board's common-anode display pins: latches one word per frame, time-multiplexes the four digits with a dead-time gap against ghosting, and decodes each nibble to active-low segments. Optional leading-zero blanking and per-digit decimal points are supported.

## Interface
- `SCAN_DIV`, 25000, clk cycles per digit slot (1 kHz slot at 25 MHz); legal range 2..65535.
- `BLANK_CYC`, 250, dead-time cycles at the start of each slot, all digits off; legal range 0..SCAN_DIV-1.
- `clk`  in  1  system clock, 25 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `display_num`  in  16  [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; hex 0–F.
- `dp_en`  in  4  decimal point enable per digit, bit i = digit i, active high.
- `blank_lz`  in  1  leading-zero blanking enable.
- `seg`  out  8  {dp,g,f,e,d,c,b,a}, active low, registered.
- `dig`  out  4  digit select, bit 0 = units, active low, registered.
- `frame_start`  out  1  one-cycle pulse marking the first output cycle of slot 0.

## Operation
- Slot counter `cnt` runs 0..SCAN_DIV-1 and wraps. Digit index `idx` (2 bits) increments 0→1→2→3→0 on wrap.
- FSM, two states:
  - S_DEAD: `dig`=4'hF, `seg`=8'hFF. Exit to S_ON when `cnt`==BLANK_CYC-1. With BLANK_CYC=0, S_DEAD is never entered.
  - S_ON: `dig`=~(1<<idx) unless the digit is blanked. `seg`={~dp_l[idx], hex2seg(nib)}. Exit to S_DEAD, or straight back to S_ON when BLANK_CYC=0, when `cnt`==SCAN_DIV-1.
- Frame latch: at `cnt`==0 with `idx`==0, capture `display_num`→`num_l`, `dp_en`→`dp_l`, `blank_lz`→`lz_l`. Input changes mid-frame are ignored until the next frame.
- `nib` = `num_l`[4·idx+3 : 4·idx].
- Leading-zero blanking, when `lz_l`=1:
  - digit 3 blanked if `num_l`[15:12]==0
  - digit 2 blanked if `num_l`[15:8]==0
  - digit 1 blanked if `num_l`[15:4]==0
  - digit 0 is never blanked.
- A blanked digit keeps `dig` at 4'hF and `seg` at 8'hFF for the entire slot, dp included.
- Decode, active low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- At most one `dig` bit is low in any cycle. `dig` is never low during S_DEAD.

## Timing
- Reset values: `seg`=8'hFF, `dig`=4'hF, `frame_start`=0, `cnt`=0, `idx`=0, `num_l`=16'h0000, `dp_l`=0, `lz_l`=0, state S_DEAD (S_ON if BLANK_CYC=0).
- First latch happens on the first clk edge after reset release. Outputs change on the following edge.
- All outputs are registered, one cycle behind `cnt`/`idx`/state.
- `frame_start` is high exactly one cycle per frame, coincident with the first output cycle of slot 0 (dead or on).
- Slot = SCAN_DIV cycles. Frame = 4·SCAN_DIV cycles. Lit time per slot = SCAN_DIV-BLANK_CYC cycles.
- A `display_num` change takes effect at most 4·SCAN_DIV+1 cycles later.
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronous). Scanning restarts at slot 0.

## Structure
- Package `seg7_pkg`:
  - 16-entry hex→segment constant table
  - SEG_OFF=8'hFF, DIG_OFF=4'hF
  - state enum {S_DEAD, S_ON}
- Sub-module `hex2seg`: combinational 4-bit → 7-bit active-low decoder using the package table. The top instantiates one copy.
- `cnt` width = $clog2(SCAN_DIV).

## Test plan
Bench uses SCAN_DIV=8, BLANK_CYC=2.
- Reset, then `display_num`=16'h1234, `dp_en`=0, `blank_lz`=0 → slot order `dig`=E,D,B,7 with `seg`=99,B0,A4,F9. Each slot shows 2 cycles of F/FF, then 6 lit cycles. `frame_start` pulses every 32 cycles.
- `display_num`=16'h0050, `blank_lz`=1 → digit 0 `seg`=C0, digit 1 `seg`=92. Digits 2 and 3 keep `dig`=F all slot.
- `display_num`=16'h0000, `blank_lz`=1 → only digit 0 lit, `seg`=C0. `dp_en`=4'b0100 → digit 2 still dark, dp suppressed.
- `display_num` changes 16'hFFFF→16'h8888 mid-frame → the current frame shows all 8E. The next frame shows all 80, starting at `frame_start`.
- BLANK_CYC=0 build → `dig` never 4'hF after the first output cycle. Each slot lit for all 8 cycles.
- Assert `rst_n` during slot 2 → `seg`=FF and `dig`=F at once. After release, the first lit digit is digit 0 and `frame_start` pulses.
